// File: rtl/mac_acc_seq.sv
// Job sequencer for the 4-lane accumulator block: captures a job command, loads the
// block through its reset, gates operand beats into it and hands the frozen result downstream.
module mac_acc_seq #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 32,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cmd_valid,
  output logic                                    cmd_ready,
  input  logic [1:0]                              cmd_mode,
  input  logic [LEN_WIDTH-1:0]                    cmd_len,
  input  logic [4*MAC_ACC_WIDTH-1:0]              cmd_init,
  input  logic                                    op_valid,
  output logic                                    op_ready,
  output logic                                    blk_rst,
  output logic                                    blk_en,
  output logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] blk_cfg,
  output logic                                    res_valid,
  input  logic                                    res_ready,
  output logic                                    busy,
  output logic [15:0]                             job_cnt
);

  if (MAC_ACC_WIDTH < MAC_MIN_WIDTH || MAC_CONF_WIDTH < 4) begin : g_bad_params
    $error("mac_acc_seq: lane width below minimum or config field too narrow");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t               state;
  state_t               next_state;
  logic [LEN_WIDTH-1:0] cnt;
  logic                 accept;
  logic                 beat;
  logic                 cmd_ready_d;
  logic                 op_ready_d;
  logic                 blk_rst_d;
  logic                 res_valid_d;

  assign accept = cmd_valid & cmd_ready;
  assign beat   = op_valid & op_ready;
  assign blk_en = beat;
  assign busy   = (state != IDLE);

  // Handshake outputs are registered from the next state so they are glitch-free
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      op_ready  <= 1'b0;
      blk_rst   <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      state     <= next_state;
      cmd_ready <= cmd_ready_d;
      op_ready  <= op_ready_d;
      blk_rst   <= blk_rst_d;
      res_valid <= res_valid_d;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (accept) next_state = LOAD;
      LOAD: next_state = (cnt == '0) ? DONE : RUN;
      RUN:  if (beat && cnt == LEN_WIDTH'(1)) next_state = DONE;
      DONE: if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d = (next_state == IDLE);
    op_ready_d  = (next_state == RUN);
    blk_rst_d   = (next_state == LOAD);
    res_valid_d = (next_state == DONE);
  end

  // Accumulate path is always selected; the cfg word is held until the next accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cfg <= '0;
      cnt     <= '0;
      job_cnt <= '0;
    end else begin
      if (accept) begin
        blk_cfg <= {cmd_init, {(MAC_CONF_WIDTH-3){1'b0}}, 1'b1, cmd_mode};
        cnt     <= cmd_len;
      end else if (beat) begin
        cnt <= cnt - LEN_WIDTH'(1);
      end
      if (state == DONE && res_ready) job_cnt <= job_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mac_acc_seq.sv
// Bench for mac_acc_seq: a stand-in accumulator block, a job-level reference model
// checked every cycle, and directed jobs with hand-computed results.
module tb_mac_acc_seq;
  localparam int CW   = 4;
  localparam int AW   = 32;
  localparam int LW   = 16;
  localparam int CFGW = 4*AW + CW;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_mode;
  logic [LW-1:0]   cmd_len;
  logic [4*AW-1:0] cmd_init;
  logic            op_valid;
  logic            op_ready;
  logic            blk_rst;
  logic            blk_en;
  logic [CFGW-1:0] blk_cfg;
  logic            res_valid;
  logic            res_ready;
  logic            busy;
  logic [15:0]     job_cnt;

  logic [31:0]  op_in [4];
  logic [31:0]  blk_out [4];
  logic [127:0] out_all;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  int en_pulses  = 0;

  always #5 clk = ~clk;

  mac_acc_seq #(.MAC_CONF_WIDTH(CW), .MAC_MIN_WIDTH(8), .MAC_ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_len(cmd_len), .cmd_init(cmd_init),
    .op_valid(op_valid), .op_ready(op_ready),
    .blk_rst(blk_rst), .blk_en(blk_en), .blk_cfg(blk_cfg),
    .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .job_cnt(job_cnt)
  );

  // Stand-in for the accumulator block: loads lanes while in reset, adds when enabled
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (blk_rst)     blk_out[k] <= blk_cfg[CW+32*k +: 32];
      else if (blk_en) blk_out[k] <= blk_out[k] + op_in[k];
    end
  end
  assign out_all = {blk_out[3], blk_out[2], blk_out[1], blk_out[0]};

  always @(posedge clk) cycle <= cycle + 1;
  always @(negedge clk) if (blk_en === 1'b1) en_pulses <= en_pulses + 1;

  task automatic check_output(input string name, input logic [135:0] act, input logic [135:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Job-level reference: what the sequencer owes its neighbours, tracked per job phase
  logic            m_ready, m_load, m_feed, m_result, m_fresh;
  int              m_left;
  logic [15:0]     m_jobs;
  logic [CFGW-1:0] m_cfg;
  logic [31:0]     m_lanes [4];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ready  <= 1'b0;
      m_load   <= 1'b0;
      m_feed   <= 1'b0;
      m_result <= 1'b0;
      m_fresh  <= 1'b1;
      m_left   <= 0;
      m_jobs   <= '0;
      m_cfg    <= '0;
    end else begin
      m_fresh <= 1'b0;
      if (m_ready && cmd_valid) begin
        m_ready <= 1'b0;
        m_load  <= 1'b1;
        m_left  <= int'(cmd_len);
        m_cfg   <= {cmd_init, 2'b01, cmd_mode};
        for (int k = 0; k < 4; k++) m_lanes[k] <= cmd_init[32*k +: 32];
      end else if (m_load) begin
        m_load <= 1'b0;
        if (m_left == 0) m_result <= 1'b1;
        else             m_feed   <= 1'b1;
      end else if (m_feed && op_valid) begin
        for (int k = 0; k < 4; k++) m_lanes[k] <= m_lanes[k] + op_in[k];
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_feed   <= 1'b0;
          m_result <= 1'b1;
        end
      end else if (m_result && res_ready) begin
        m_result <= 1'b0;
        m_jobs   <= m_jobs + 16'd1;
        m_ready  <= 1'b1;
      end else if (!m_load && !m_feed && !m_result) begin
        m_ready <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check_output("cmd_ready", cmd_ready, m_ready);
    check_output("op_ready", op_ready, m_feed);
    check_output("blk_rst", blk_rst, m_load | m_fresh);
    check_output("blk_en", blk_en, m_feed & op_valid);
    check_output("res_valid", res_valid, m_result);
    check_output("busy", busy, m_load | m_feed | m_result);
    check_output("job_cnt", job_cnt, m_jobs);
    check_output("blk_cfg", blk_cfg, m_cfg);
    if (m_result) begin
      for (int k = 0; k < 4; k++) check_output("lane_result", blk_out[k], m_lanes[k]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] mode, input int len, input logic [127:0] init,
                          output int accept_cycle);
    logic acc;
    acc = 1'b0;
    accept_cycle = -1;
    cmd_mode  = mode;
    cmd_len   = LW'(len);
    cmd_init  = init;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = cmd_ready;
      accept_cycle = cycle;
      tick();
      if (acc) break;
    end
    cmd_valid = 1'b0;
    if (!acc) check_output("cmd_accept_timeout", 0, 1);
  endtask

  task automatic apply_stimulus(input int len, input logic [127:0] beat, input bit toggle,
                                output int last_cycle);
    int got;
    got = 0;
    last_cycle = -1;
    for (int k = 0; k < 4; k++) op_in[k] = beat[32*k +: 32];
    for (int i = 0; i < 200 && got < len; i++) begin
      op_valid = toggle ? (i % 2 == 0) : 1'b1;
      if (op_valid && op_ready) begin
        got++;
        last_cycle = cycle;
      end
      tick();
    end
    op_valid = 1'b0;
    for (int k = 0; k < 4; k++) op_in[k] = 32'hFFFF_FFFF;
    if (got < len) check_output("beat_timeout", got, len);
  endtask

  task automatic wait_result(input int budget);
    int n;
    n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    if (!res_valid) check_output("res_valid_timeout", 0, 1);
  endtask

  task automatic finish_job();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int t0, last, base;
    logic [127:0] snap;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_len = '0; cmd_init = '0;
    op_valid = 1'b0; res_ready = 1'b0;
    for (int k = 0; k < 4; k++) op_in[k] = 32'd0;
    #2 rst = 1'b0;
    op_valid = 1'b1;
    repeat (3) tick();
    check_output("rst_blk_rst", blk_rst, 1'b1);
    check_output("rst_cmd_ready", cmd_ready, 1'b0);
    check_output("rst_blk_en", blk_en, 1'b0);
    check_output("rst_blk_cfg", blk_cfg, 0);
    check_output("rst_job_cnt", job_cnt, 0);
    op_valid = 1'b0;
    rst = 1'b1;
    tick();

    // QUAD, len 3, beats of 1 into a zeroed accumulator
    send_cmd(2'd2, 3, 128'd0, t0);
    check_output("t1_load_blk_rst", blk_rst, 1'b1);
    base = en_pulses;
    apply_stimulus(3, 128'd1, 1'b0, last);
    check_output("t1_res_valid", res_valid, 1'b1);
    check_output("t1_latency", cycle - last, 1);
    check_output("t1_out", out_all, 128'd3);
    check_output("t1_pulses", en_pulses - base, 3);
    finish_job();
    check_output("t1_job_cnt", job_cnt, 16'd1);

    // SINGLE, len 4, lanes start {1,2,3,4}, each beat adds 5 per lane
    send_cmd(2'd0, 4, {32'd4, 32'd3, 32'd2, 32'd1}, t0);
    check_output("t2_cfg_low", blk_cfg[3:0], 4'h4);
    check_output("t2_cfg_lane0", blk_cfg[35:4], 32'd1);
    apply_stimulus(4, {32'd5, 32'd5, 32'd5, 32'd5}, 1'b0, last);
    check_output("t2_out", out_all, {32'd24, 32'd23, 32'd22, 32'd21});
    finish_job();

    // DUAL, len 4 with op_valid toggling: exactly four enables
    base = en_pulses;
    send_cmd(2'd1, 4, 128'd0, t0);
    apply_stimulus(4, 128'd2, 1'b1, last);
    check_output("t3_pulses", en_pulses - base, 4);
    check_output("t3_latency", cycle - last, 1);
    check_output("t3_res_valid", res_valid, 1'b1);
    check_output("t3_out", out_all, 128'd8);
    finish_job();

    // len 0: result is the initial value, operands offered but never taken
    base = en_pulses;
    op_valid = 1'b1;
    send_cmd(2'd2, 0, 128'hDEAD, t0);
    wait_result(10);
    op_valid = 1'b0;
    check_output("t4_latency", cycle - t0, 2);
    check_output("t4_out0", out_all[31:0], 32'hDEAD);
    check_output("t4_pulses", en_pulses - base, 0);
    finish_job();

    // Result held under back-pressure while a new command waits
    send_cmd(2'd2, 1, 128'd7 << 32, t0);
    apply_stimulus(1, 128'd1, 1'b0, last);
    snap = out_all;
    check_output("t5_out", snap, {64'd0, 32'd7, 32'd1});
    cmd_mode = 2'd0; cmd_len = '0; cmd_init = 128'h55; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_output("t5_hold_valid", res_valid, 1'b1);
      check_output("t5_hold_cmd_ready", cmd_ready, 1'b0);
      check_output("t5_hold_out", out_all, snap);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_output("t5_idle_cmd_ready", cmd_ready, 1'b1);
    check_output("t5_idle_busy", busy, 1'b0);
    tick();
    cmd_valid = 1'b0;
    wait_result(10);
    check_output("t5_next_out", out_all, 128'h55);
    finish_job();
    check_output("t5_job_cnt", job_cnt, 16'd6);

    // Reset mid-RUN with two beats still owed, then a clean job
    send_cmd(2'd2, 4, 128'd0, t0);
    apply_stimulus(2, 128'd1, 1'b0, last);
    #2 rst = 1'b0;
    #1;
    check_output("t6_busy", busy, 1'b0);
    check_output("t6_blk_rst", blk_rst, 1'b1);
    check_output("t6_job_cnt", job_cnt, 16'd0);
    check_output("t6_op_ready", op_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    send_cmd(2'd0, 2, 128'd10, t0);
    apply_stimulus(2, 128'd1, 1'b0, last);
    check_output("t6_out", out_all, 128'd12);
    finish_job();
    check_output("t6_job_cnt_after", job_cnt, 16'd1);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
